cnn_layer_sequencer: RTL and testbench

Central controller inside `CNN_top` that runs one full inference. It launches each layer engine in a fixed order: conv1, pool1, conv2, pool2, fc1, fc2. It waits for each engine's done, flips the ping-pong feature-buffer select between layers, and guards every layer with a watchdog. It also reduces the final FC score stream to a class index through an argmax stage. This replaces free-running layer chaining, so the top-level `class` output gets a defined valid strobe and an error path.

---
 rtl/cnn_pkg.sv | 25 ++
 rtl/cnn_argmax.sv | 69 ++++++
 rtl/cnn_layer_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_cnn_layer_sequencer.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN layer sequencer: FSM state encoding,
// layer index constants and default sizing.
package cnn_pkg;

    localparam int unsigned N_LAYERS_DEF  = 6;
    localparam int unsigned N_CLASSES_DEF = 10;

    localparam int unsigned L_CONV1 = 0;
    localparam int unsigned L_POOL1 = 1;
    localparam int unsigned L_CONV2 = 2;
    localparam int unsigned L_POOL2 = 3;
    localparam int unsigned L_FC1   = 4;
    localparam int unsigned L_FC2   = 5;

    localparam int unsigned STATE_W = 3;
    typedef logic [STATE_W-1:0] seq_state_t;

    localparam seq_state_t S_IDLE   = 3'd0;
    localparam seq_state_t S_LAUNCH = 3'd1;
    localparam seq_state_t S_WAIT   = 3'd2;
    localparam seq_state_t S_FINISH = 3'd3;
    localparam seq_state_t S_DONE   = 3'd4;
    localparam seq_state_t S_ERR    = 3'd5;

endpackage

// File: rtl/cnn_argmax.sv
// Streaming signed argmax over the FC score beats; ties keep the lower index,
// beats past N_CLASSES are ignored, score_last raises the complete flag.
module cnn_argmax
    import cnn_pkg::*;
#(
    parameter int unsigned N_CLASSES = N_CLASSES_DEF,
    parameter int unsigned CLASS_W   = 4,
    parameter int unsigned SCORE_W   = 16
) (
    input  logic               clk_in,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               enable,
    input  logic               score_valid,
    input  logic [SCORE_W-1:0] score_data,
    input  logic               score_last,
    output logic [CLASS_W-1:0] max_idx,
    output logic               complete
);
    localparam int unsigned CNT_W = $clog2(N_CLASSES + 1);

    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SCORE_W-1:0] max_q, max_d;
    logic [CLASS_W-1:0] idx_q, idx_d;
    logic               complete_q, complete_d;

    always_comb begin
        cnt_d      = cnt_q;
        max_d      = max_q;
        idx_d      = idx_q;
        complete_d = complete_q;
        if (clear) begin
            cnt_d      = '0;
            max_d      = '0;
            idx_d      = '0;
            complete_d = 1'b0;
        end else if (enable && score_valid) begin
            // Counter saturates at N_CLASSES so late beats can never be selected
            if (cnt_q < CNT_W'(N_CLASSES)) begin
                if ((cnt_q == '0) || ($signed(score_data) > $signed(max_q))) begin
                    max_d = score_data;
                    idx_d = CLASS_W'(cnt_q);
                end
                cnt_d = cnt_q + CNT_W'(1);
            end
            if (score_last) begin
                complete_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            max_q      <= '0;
            idx_q      <= '0;
            complete_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            max_q      <= max_d;
            idx_q      <= idx_d;
            complete_q <= complete_d;
        end
    end

    assign max_idx  = idx_q;
    assign complete = complete_q;

endmodule

// File: rtl/cnn_layer_sequencer.sv
// Runs one CNN inference: launches the six layer engines in order with a
// per-layer watchdog, flips the ping-pong buffer and reports the argmax class.
// Optional cycle counter on perf_cycles when CNN_SEQ_PERF_EN is defined.
module cnn_layer_sequencer
    import cnn_pkg::*;
#(
    parameter int unsigned N_LAYERS       = N_LAYERS_DEF,
    parameter int unsigned N_CLASSES      = N_CLASSES_DEF,
    parameter int unsigned CLASS_W        = 4,
    parameter int unsigned SCORE_W        = 16,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic                clk_in,
    input  logic                rst_n,
    input  logic                start,
    output logic                busy,
    output logic [N_LAYERS-1:0] layer_start,
    input  logic [N_LAYERS-1:0] layer_done,
    output logic                buf_sel,
    input  logic                score_valid,
    input  logic [SCORE_W-1:0]  score_data,
    input  logic                score_last,
    output logic [CLASS_W-1:0]  class_out,
    output logic                class_valid,
`ifdef CNN_SEQ_PERF_EN
    output logic [31:0]         perf_cycles,
`endif
    output logic                error
);
    localparam int unsigned IDX_W = (N_LAYERS > 1) ? $clog2(N_LAYERS) : 1;
    localparam int unsigned WD_W  = $clog2(TIMEOUT_CYCLES + 1);

    seq_state_t          state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                buf_sel_q, buf_sel_d;
    logic                busy_q, busy_d;
    logic [N_LAYERS-1:0] layer_start_q, layer_start_d;
    logic [CLASS_W-1:0]  class_out_q, class_out_d;
    logic                class_valid_q, class_valid_d;
    logic                error_q, error_d;
    logic [WD_W-1:0]     wdog_q, wdog_d;
    logic                start_acc_c;
    logic                am_en_c;
    logic                timeout_c;
    logic [CLASS_W-1:0]  am_idx;
    logic                am_complete;

    cnn_argmax #(
        .N_CLASSES (N_CLASSES),
        .CLASS_W   (CLASS_W),
        .SCORE_W   (SCORE_W)
    ) u_argmax (
        .clk_in      (clk_in),
        .rst_n       (rst_n),
        .clear       (start_acc_c),
        .enable      (am_en_c),
        .score_valid (score_valid),
        .score_data  (score_data),
        .score_last  (score_last),
        .max_idx     (am_idx),
        .complete    (am_complete)
    );

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        buf_sel_d     = buf_sel_q;
        busy_d        = busy_q;
        layer_start_d = '0;
        class_out_d   = class_out_q;
        class_valid_d = 1'b0;
        error_d       = error_q;
        wdog_d        = wdog_q;
        start_acc_c   = 1'b0;
        am_en_c       = (state_q != S_IDLE) && (state_q != S_ERR);
        timeout_c     = (wdog_q == WD_W'(TIMEOUT_CYCLES - 1));

        case (state_q)
            S_IDLE, S_ERR: begin
                if (start) begin
                    start_acc_c   = 1'b1;
                    state_d       = S_LAUNCH;
                    idx_d         = '0;
                    buf_sel_d     = 1'b0;
                    busy_d        = 1'b1;
                    error_d       = 1'b0;
                    class_out_d   = '0;
                    layer_start_d = N_LAYERS'(1);
                end
            end
            S_LAUNCH: begin
                wdog_d  = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // A done in the timeout cycle still wins over the watchdog
                if (layer_done[idx_q]) begin
                    if (idx_q == IDX_W'(N_LAYERS - 1)) begin
                        state_d = S_FINISH;
                    end else begin
                        idx_d         = idx_q + IDX_W'(1);
                        buf_sel_d     = ~buf_sel_q;
                        layer_start_d = N_LAYERS'(1) << (idx_q + IDX_W'(1));
                        state_d       = S_LAUNCH;
                    end
                end else if (timeout_c) begin
                    state_d = S_ERR;
                    error_d = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    wdog_d = wdog_q + WD_W'(1);
                end
            end
            S_FINISH: begin
                if (am_complete) begin
                    state_d       = S_DONE;
                    class_out_d   = am_idx;
                    class_valid_d = 1'b1;
                end else if (timeout_c) begin
                    state_d = S_ERR;
                    error_d = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    wdog_d = wdog_q + WD_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            idx_q         <= '0;
            buf_sel_q     <= 1'b0;
            busy_q        <= 1'b0;
            layer_start_q <= '0;
            class_out_q   <= '0;
            class_valid_q <= 1'b0;
            error_q       <= 1'b0;
            wdog_q        <= '0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            buf_sel_q     <= buf_sel_d;
            busy_q        <= busy_d;
            layer_start_q <= layer_start_d;
            class_out_q   <= class_out_d;
            class_valid_q <= class_valid_d;
            error_q       <= error_d;
            wdog_q        <= wdog_d;
        end
    end

`ifdef CNN_SEQ_PERF_EN
    logic [31:0] perf_q, perf_d;

    // Counts busy cycles of the current run and holds once busy drops
    always_comb begin
        perf_d = perf_q;
        if (start_acc_c) begin
            perf_d = '0;
        end else if (busy_q) begin
            perf_d = perf_q + 32'd1;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            perf_q <= '0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign perf_cycles = perf_q;
`endif

    assign busy        = busy_q;
    assign layer_start = layer_start_q;
    assign buf_sel     = buf_sel_q;
    assign class_out   = class_out_q;
    assign class_valid = class_valid_q;
    assign error       = error_q;

endmodule

// File: tb/tb_cnn_layer_sequencer.sv
// Bench for cnn_layer_sequencer: a timeline model derives expected outputs
// from the per-cycle stimulus tables; literal checks pin key cycles.
module tb_cnn_layer_sequencer;
    localparam int NL = 6;
    localparam int NC = 10;
    localparam int CW = 4;
    localparam int SW = 16;
    localparam int TO = 100;
    localparam int NW = 260;

    logic          clk_in = 1'b0;
    logic          rst_n;
    logic          start;
    logic [NL-1:0] layer_done;
    logic          score_valid;
    logic [SW-1:0] score_data;
    logic          score_last;
    logic          busy;
    logic [NL-1:0] layer_start;
    logic          buf_sel;
    logic [CW-1:0] class_out;
    logic          class_valid;
    logic          error;
`ifdef CNN_SEQ_PERF_EN
    logic [31:0]   perf_cycles;
`endif

    cnn_layer_sequencer #(
        .N_LAYERS       (NL),
        .N_CLASSES      (NC),
        .CLASS_W        (CW),
        .SCORE_W        (SW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk_in      (clk_in),
        .rst_n       (rst_n),
        .start       (start),
        .busy        (busy),
        .layer_start (layer_start),
        .layer_done  (layer_done),
        .buf_sel     (buf_sel),
        .score_valid (score_valid),
        .score_data  (score_data),
        .score_last  (score_last),
        .class_out   (class_out),
        .class_valid (class_valid),
`ifdef CNN_SEQ_PERF_EN
        .perf_cycles (perf_cycles),
`endif
        .error       (error)
    );

    always #5 clk_in = ~clk_in;

    // Per-cycle stimulus tables
    logic                 drv_start [NW];
    logic [NL-1:0]        drv_done  [NW];
    logic                 drv_sv    [NW];
    logic signed [SW-1:0] drv_sd    [NW];
    logic                 drv_sl    [NW];

    // Expected and observed outputs per cycle
    logic [NL-1:0] exp_ls [NW];
    logic          exp_busy [NW];
    logic          exp_buf [NW];
    logic          exp_cv [NW];
    logic          exp_err [NW];
    logic [CW-1:0] exp_co [NW];
    logic [NL-1:0] obs_ls [NW];
    logic          obs_busy [NW];
    logic          obs_buf [NW];
    logic          obs_cv [NW];
    logic          obs_err [NW];
    logic [CW-1:0] obs_co [NW];

    int n_checks = 0;
    int n_fails  = 0;
    int cur_c    = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input int cyc, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act !== want) begin
            n_fails++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, act, want);
        end
    endtask

    task automatic clear_stim();
        for (int i = 0; i < NW; i++) begin
            drv_start[i] = 1'b0;
            drv_done[i]  = '0;
            drv_sv[i]    = 1'b0;
            drv_sd[i]    = '0;
            drv_sl[i]    = 1'b0;
        end
    endtask

    task automatic add_beat(input int c, input int v, input bit last);
        drv_sv[c] = 1'b1;
        drv_sd[c] = SW'(v);
        drv_sl[c] = last;
    endtask

    task automatic add_nominal_dones();
        for (int k = 0; k < NL; k++) drv_done[6 + 6 * k][k] = 1'b1;
    endtask

    // Timeline model: walks accepted starts, layer launches and dones by the
    // documented latencies and writes the resulting output levels per cycle.
    task automatic build_model(input int len);
        int c, s, L, d, fin, cl, f, D, E, beat, best_i;
        bit ok;
        logic signed [SW-1:0] best;
        for (int i = 0; i < NW; i++) begin
            exp_ls[i] = '0; exp_busy[i] = 1'b0; exp_buf[i] = 1'b0;
            exp_cv[i] = 1'b0; exp_err[i] = 1'b0; exp_co[i] = '0;
        end
        c = 0;
        while (c < len) begin
            if (!drv_start[c]) begin
                c++;
                continue;
            end
            s = c;
            for (int i = s + 1; i < len; i++) begin
                exp_co[i] = '0; exp_err[i] = 1'b0; exp_buf[i] = 1'b0; exp_busy[i] = 1'b1;
            end
            L = s + 1; ok = 1'b1; fin = -1; E = len;
            for (int k = 0; k < NL && ok; k++) begin
                if (L < len) exp_ls[L] = NL'(1) << k;
                for (int i = L; i < len; i++) exp_buf[i] = k[0];
                d = -1;
                for (int i = L + 1; i <= L + TO && i < len; i++) begin
                    if (drv_done[i][k]) begin
                        d = i;
                        break;
                    end
                end
                if (d < 0) begin
                    ok = 1'b0;
                    E = L + TO + 1;
                end else if (k < NL - 1) begin
                    L = d + 1;
                end else begin
                    fin = d;
                end
            end
            if (!ok) begin
                for (int i = E; i < len; i++) begin
                    exp_err[i] = 1'b1; exp_busy[i] = 1'b0;
                end
                c = E;
                continue;
            end
            cl = -1;
            for (int i = s + 1; i < len; i++) begin
                if (drv_sv[i] && drv_sl[i]) begin
                    cl = i;
                    break;
                end
            end
            if (cl < 0) begin
                c = len;
                continue;
            end
            f = (fin + 1 > cl + 1) ? fin + 1 : cl + 1;
            D = f + 1;
            beat = 0; best = '0; best_i = 0;
            for (int i = s + 1; i < f; i++) begin
                if (drv_sv[i]) begin
                    if (beat < NC && (beat == 0 || drv_sd[i] > best)) begin
                        best = drv_sd[i];
                        best_i = beat;
                    end
                    beat++;
                end
            end
            if (D < len) exp_cv[D] = 1'b1;
            for (int i = D; i < len; i++) exp_co[i] = CW'(best_i);
            for (int i = D + 1; i < len; i++) exp_busy[i] = 1'b0;
            c = D + 1;
        end
    endtask

    // Compare process: every cycle of an active scenario
    always @(negedge clk_in) begin
        if (chk_en) begin
            obs_ls[cur_c] = layer_start; obs_busy[cur_c] = busy; obs_buf[cur_c] = buf_sel;
            obs_cv[cur_c] = class_valid; obs_err[cur_c] = error; obs_co[cur_c] = class_out;
            check("layer_start", cur_c, 32'(layer_start), 32'(exp_ls[cur_c]));
            check("busy",        cur_c, 32'(busy),        32'(exp_busy[cur_c]));
            check("buf_sel",     cur_c, 32'(buf_sel),     32'(exp_buf[cur_c]));
            check("class_valid", cur_c, 32'(class_valid), 32'(exp_cv[cur_c]));
            check("class_out",   cur_c, 32'(class_out),   32'(exp_co[cur_c]));
            check("error",       cur_c, 32'(error),       32'(exp_err[cur_c]));
        end
    end

    task automatic zero_inputs();
        start = 1'b0; layer_done = '0; score_valid = 1'b0; score_data = '0; score_last = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        zero_inputs();
        repeat (2) @(posedge clk_in);
        #1 rst_n = 1'b1;
    endtask

    task automatic run_scn(input int len);
        build_model(len);
        for (int c = 0; c < len; c++) begin
            @(posedge clk_in);
            #1;
            cur_c       = c;
            start       = drv_start[c];
            layer_done  = drv_done[c];
            score_valid = drv_sv[c];
            score_data  = drv_sd[c];
            score_last  = drv_sl[c];
            chk_en      = 1'b1;
        end
        @(posedge clk_in);
        #1;
        chk_en = 1'b0;
        zero_inputs();
    endtask

    initial begin
        int nom[10];
        int toggles;
        nom = '{3, -2, 9, 9, 1, 0, 4, -7, 2, 8};

        do_reset();
        check("reset_busy",        0, 32'(busy),        32'd0);
        check("reset_layer_start", 0, 32'(layer_start), 32'd0);
        check("reset_error",       0, 32'(error),       32'd0);
        check("reset_class_out",   0, 32'(class_out),   32'd0);

        // Nominal run
        clear_stim();
        drv_start[0] = 1'b1;
        add_nominal_dones();
        for (int i = 0; i < 10; i++) add_beat(20 + i, nom[i], i == 9);
        run_scn(60);
        check("model_cv_38", 38, 32'(exp_cv[38]), 32'd1);
        check("model_co_38", 38, 32'(exp_co[38]), 32'd2);
        for (int k = 0; k < NL; k++)
            check("nom_launch", 1 + 6 * k, 32'(obs_ls[1 + 6 * k]), 32'(1 << k));
        check("nom_class_valid", 38, 32'(obs_cv[38]), 32'd1);
        check("nom_class_out",   38, 32'(obs_co[38]), 32'd2);
        check("nom_busy_fall",   39, 32'(obs_busy[39]), 32'd0);
        toggles = 0;
        for (int i = 1; i < 60; i++) if (obs_buf[i] != obs_buf[i - 1]) toggles++;
        check("nom_buf_toggles", 0, 32'(toggles), 32'd5);
`ifdef CNN_SEQ_PERF_EN
        check("perf_cycles", 60, perf_cycles, 32'd38);
`endif

        // Stray done, start while busy, ties, beat past N_CLASSES, last with final done
        do_reset();
        clear_stim();
        drv_start[0] = 1'b1;
        drv_start[15] = 1'b1;
        add_nominal_dones();
        drv_done[9][3] = 1'b1;
        for (int i = 0; i < 10; i++) add_beat(26 + i, -3, 1'b0);
        add_beat(36, 100, 1'b1);
        run_scn(60);
        check("stray_launch2", 13, 32'(obs_ls[13]), 32'd4);
        check("stray_cv",      38, 32'(obs_cv[38]), 32'd1);
        check("stray_class",   38, 32'(obs_co[38]), 32'd0);

        // Timeout on layer 2, restart, done landing on the watchdog limit
        do_reset();
        clear_stim();
        drv_start[0] = 1'b1;
        drv_done[6][0] = 1'b1;
        drv_done[12][1] = 1'b1;
        drv_start[120] = 1'b1;
        drv_done[221][0] = 1'b1;
        run_scn(240);
        check("to_err_before", 113, 32'(obs_err[113]), 32'd0);
        check("to_err_set",    114, 32'(obs_err[114]), 32'd1);
        check("to_busy_low",   114, 32'(obs_busy[114]), 32'd0);
        check("to_restart",    121, 32'(obs_ls[121]), 32'd1);
        check("to_err_clear",  121, 32'(obs_err[121]), 32'd0);
        check("to_edge_done",  222, 32'(obs_ls[222]), 32'd2);
        check("to_edge_noerr", 239, 32'(obs_err[239]), 32'd0);

        // Late scores, all negative
        do_reset();
        clear_stim();
        drv_start[0] = 1'b1;
        add_nominal_dones();
        add_beat(45, -5, 1'b0);
        add_beat(46, -1, 1'b0);
        add_beat(47, -1, 1'b1);
        run_scn(60);
        check("late_busy",  48, 32'(obs_busy[48]), 32'd1);
        check("late_cv",    49, 32'(obs_cv[49]), 32'd1);
        check("late_class", 49, 32'(obs_co[49]), 32'd1);

        // Reset asserted mid-WAIT
        do_reset();
        clear_stim();
        drv_start[0] = 1'b1;
        drv_done[6][0] = 1'b1;
        run_scn(10);
        check("pre_rst_busy", 10, 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_busy",        10, 32'(busy),        32'd0);
        check("rst_layer_start", 10, 32'(layer_start), 32'd0);
        check("rst_buf_sel",     10, 32'(buf_sel),     32'd0);
        check("rst_error",       10, 32'(error),       32'd0);
        check("rst_class_valid", 10, 32'(class_valid), 32'd0);
        check("rst_class_out",   10, 32'(class_out),   32'd0);
        repeat (2) @(posedge clk_in);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_in);
            check("post_rst_layer_start", i, 32'(layer_start), 32'd0);
            check("post_rst_busy",        i, 32'(busy),        32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
